// File: rtl/if_stage.sv
// Instruction fetch stage.
//
// Owns the fetch PC, issues word reads on a pipelined instruction bus, and
// buffers returned words until the decode stage takes them over the IF/ID
// interface.
//
// Ports:
//   clk, rst              core clock, asynchronous active-high reset
//   if_stall              decode not accepting; hold the current IF/ID output
//   if_flush, redirect_pc redirect to a new fetch PC
//   ibus_*                read request / in-order response bus
//   if2id_pipeline_ctrl   valid (+ misaligned-fetch exception flag)
//   if2id_pipeline_data   pc and instruction of the buffer head
//
// Optional feature macro: IF_MISALIGN_CHECK_EN
//   defined   - a misaligned redirect_pc produces one exception entry and fetch
//               halts until the next redirect
//   undefined - redirect_pc[1:0] is ignored (treated as zero)

package if_stage_pkg;

  typedef struct packed {
`ifdef IF_MISALIGN_CHECK_EN
    logic exception_instr_addr_misaligned;
`endif
    logic valid;
  } if2id_pipeline_ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } if2id_pipeline_data_t;

endpackage

module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_stall,
  input  logic                 if_flush,
  input  logic [31:0]          redirect_pc,
  output logic                 ibus_read,
  output logic [31:0]          ibus_address,
  input  logic                 ibus_waitrequest,
  input  logic                 ibus_readdatavalid,
  input  logic [31:0]          ibus_readdata,
  output if2id_pipeline_ctrl_t if2id_pipeline_ctrl,
  output if2id_pipeline_data_t if2id_pipeline_data
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned IdxW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef logic [CntW-1:0] cnt_t;
  typedef logic [IdxW-1:0] idx_t;

  localparam cnt_t        MaxCnt = cnt_t'(MAX_OUTSTANDING);
  localparam logic [CntW:0] MaxSum = (CntW + 1)'(MAX_OUTSTANDING);
  localparam idx_t        LastIdx = idx_t'(MAX_OUTSTANDING - 1);

  function automatic idx_t idx_inc(input idx_t i);
    return (i == LastIdx) ? '0 : i + 1'b1;
  endfunction

  // State
  logic        run_q;
  logic [31:0] pc_q, pc_d;
  cnt_t        out_q, out_d;      // accepted requests whose response is still owed
  cnt_t        disc_q, disc_d;    // owed responses that belong to a flushed stream
  cnt_t        bcnt_q, bcnt_d;
  idx_t        bhead_q, bhead_d, btail_q, btail_d;
  idx_t        rhead_q, rhead_d, rtail_q, rtail_d;
  logic [31:0] buf_pc_q  [MAX_OUTSTANDING];
  logic [31:0] buf_ins_q [MAX_OUTSTANDING];
  logic [31:0] rpc_q     [MAX_OUTSTANDING];
`ifdef IF_MISALIGN_CHECK_EN
  logic        buf_exc_q [MAX_OUTSTANDING];
  logic        halt_q, halt_d;
  logic        misalign;
`endif

  logic          pop, accept, rsp, rsp_drop, push;
  logic [CntW:0] credit_use;
  logic [31:0]   redir_pc;

`ifdef IF_MISALIGN_CHECK_EN
  assign redir_pc = redirect_pc;
  assign misalign = if_flush & (redirect_pc[1:0] != 2'b00);
`else
  logic unused_redir_lsb;
  assign redir_pc         = {redirect_pc[31:2], 2'b00};
  assign unused_redir_lsb = ^redirect_pc[1:0];
`endif

  always_comb begin
    pop = (bcnt_q != '0) & ~if_stall & ~if_flush;
    // The entry leaving this cycle frees its slot in time for a new request, which
    // is what lets back-to-back single-cycle responses stream at one per cycle.
    credit_use = {1'b0, out_q} + {1'b0, bcnt_q} - {{CntW{1'b0}}, pop};
    ibus_read  = run_q & ~if_flush & (credit_use < MaxSum);
`ifdef IF_MISALIGN_CHECK_EN
    ibus_read  = ibus_read & ~halt_q;
`endif
    ibus_address = pc_q;
    accept       = ibus_read & ~ibus_waitrequest;
    // A response with nothing owed (e.g. left over from before reset) is ignored.
    rsp          = ibus_readdatavalid & (out_q != '0);
    rsp_drop     = rsp & (disc_q != '0);
    push         = rsp & ~rsp_drop & ~if_flush;
  end

  always_comb begin
    pc_d    = pc_q;
    out_d   = out_q + cnt_t'(accept) - cnt_t'(rsp);
    disc_d  = rsp_drop ? disc_q - 1'b1 : disc_q;
    bcnt_d  = bcnt_q + cnt_t'(push) - cnt_t'(pop);
    bhead_d = pop ? idx_inc(bhead_q) : bhead_q;
    btail_d = push ? idx_inc(btail_q) : btail_q;
    rhead_d = push ? idx_inc(rhead_q) : rhead_q;
    rtail_d = accept ? idx_inc(rtail_q) : rtail_q;
`ifdef IF_MISALIGN_CHECK_EN
    halt_d  = halt_q;
`endif
    if (accept) begin
      pc_d = pc_q + 32'd4;
    end
    if (if_flush) begin
      // No request is issued this cycle, so every owed response except one
      // arriving right now belongs to the abandoned stream.
      pc_d    = redir_pc;
      disc_d  = out_q - cnt_t'(rsp);
      bcnt_d  = '0;
      bhead_d = '0;
      btail_d = '0;
      rhead_d = '0;
      rtail_d = '0;
`ifdef IF_MISALIGN_CHECK_EN
      halt_d  = misalign;
      if (misalign) begin
        bcnt_d  = cnt_t'(1);
        btail_d = idx_inc('0);
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q   <= 1'b0;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      disc_q  <= '0;
      bcnt_q  <= '0;
      bhead_q <= '0;
      btail_q <= '0;
      rhead_q <= '0;
      rtail_q <= '0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        buf_pc_q[i]  <= '0;
        buf_ins_q[i] <= '0;
        rpc_q[i]     <= '0;
`ifdef IF_MISALIGN_CHECK_EN
        buf_exc_q[i] <= 1'b0;
`endif
      end
`ifdef IF_MISALIGN_CHECK_EN
      halt_q  <= 1'b0;
`endif
    end else begin
      run_q   <= 1'b1;
      pc_q    <= pc_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      bcnt_q  <= bcnt_d;
      bhead_q <= bhead_d;
      btail_q <= btail_d;
      rhead_q <= rhead_d;
      rtail_q <= rtail_d;
`ifdef IF_MISALIGN_CHECK_EN
      halt_q  <= halt_d;
`endif
      if (accept) begin
        rpc_q[rtail_q] <= pc_q;
      end
      if (push) begin
        buf_pc_q[btail_q]  <= rpc_q[rhead_q];
        buf_ins_q[btail_q] <= ibus_readdata;
`ifdef IF_MISALIGN_CHECK_EN
        buf_exc_q[btail_q] <= 1'b0;
`endif
      end
`ifdef IF_MISALIGN_CHECK_EN
      if (misalign) begin
        buf_pc_q[0]  <= redirect_pc;
        buf_ins_q[0] <= 32'h0;
        buf_exc_q[0] <= 1'b1;
      end
`endif
    end
  end

  // Outputs are a mux over flops only; nothing from the ibus reaches them directly.
  always_comb begin
    if2id_pipeline_ctrl       = '0;
    if2id_pipeline_data       = '0;
    if2id_pipeline_ctrl.valid = (bcnt_q != '0);
    if (bcnt_q != '0) begin
      if2id_pipeline_data.pc          = buf_pc_q[bhead_q];
      if2id_pipeline_data.instruction = buf_ins_q[bhead_q];
`ifdef IF_MISALIGN_CHECK_EN
      if2id_pipeline_ctrl.exception_instr_addr_misaligned = buf_exc_q[bhead_q];
`endif
    end
  end

  // The credit rule keeps the buffer from overflowing.
  assert property (@(posedge clk) disable iff (rst) push |-> (bcnt_q < MaxCnt));
  // A response with nothing owed indicates a bus protocol problem.
  assert property (@(posedge clk) disable iff (rst) ibus_readdatavalid |-> (out_q != '0));

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a random-latency in-order bus model, random
// stall/redirect stimulus, and a scoreboard fed with the expected instruction
// stream of each fetch segment.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam int unsigned MaxOut  = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 if_stall, if_flush;
  logic [31:0]          redirect_pc;
  logic                 ibus_read;
  logic [31:0]          ibus_address;
  logic                 ibus_waitrequest, ibus_readdatavalid;
  logic [31:0]          ibus_readdata;
  if2id_pipeline_ctrl_t ctrl;
  if2id_pipeline_data_t data;

  if_stage #(
    .RESET_PC        (ResetPc),
    .MAX_OUTSTANDING (MaxOut)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .if_stall            (if_stall),
    .if_flush            (if_flush),
    .redirect_pc         (redirect_pc),
    .ibus_read           (ibus_read),
    .ibus_address        (ibus_address),
    .ibus_waitrequest    (ibus_waitrequest),
    .ibus_readdatavalid  (ibus_readdatavalid),
    .ibus_readdata       (ibus_readdata),
    .if2id_pipeline_ctrl (ctrl),
    .if2id_pipeline_data (data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // Expected instruction stream of the current fetch segment.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        exc;
  } exp_t;
  exp_t exp_q[$];

  task automatic push_stream(input logic [31:0] base);
    logic [31:0] a;
    exp_t e;
    a = base;
    for (int i = 0; i < 64; i++) begin
      e.pc = a; e.ins = mem_word(a); e.exc = 1'b0;
      exp_q.push_back(e);
      a = a + 32'd4;
    end
  endtask

  // Bus model
  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;
  req_t pend_q[$];
  int   wait_pct = 0;
  int   max_lat  = 1;
  logic halted   = 1'b0;

  initial begin : bus_model
    int          cyc;
    logic        prev_wait_req;
    logic [31:0] prev_addr;
    req_t        r;
    cyc = 0; prev_wait_req = 1'b0; prev_addr = '0;
    ibus_waitrequest = 1'b0; ibus_readdatavalid = 1'b0; ibus_readdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pend_q.delete();
        ibus_waitrequest = 1'b0; ibus_readdatavalid = 1'b0; prev_wait_req = 1'b0;
        continue;
      end
      ibus_waitrequest = ($urandom_range(99) < wait_pct);
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        ibus_readdatavalid = 1'b1;
        ibus_readdata      = mem_word(pend_q[0].addr);
        void'(pend_q.pop_front());
      end else begin
        ibus_readdatavalid = 1'b0;
        ibus_readdata      = $urandom;
      end
      #1;
      if (prev_wait_req && !if_flush)
        check("ibus_hold", {31'b0, ibus_read, ibus_address}, {31'b0, 1'b1, prev_addr});
      if (halted) check("halt_no_read", {63'b0, ibus_read}, 64'd0);
      if (ibus_read && !ibus_waitrequest) begin
        check("credit_limit", {63'b0, pend_q.size() < MaxOut}, 64'd1);
        check("addr_align", {62'b0, ibus_address[1:0]}, 64'd0);
        r.addr = ibus_address;
        r.due  = cyc + $urandom_range(max_lat, 1);
        pend_q.push_back(r);
      end
      prev_wait_req = ibus_read & ibus_waitrequest;
      prev_addr     = ibus_address;
    end
  end

  // Monitor / scoreboard
  int   pops = 0;
  int   pop_cyc[$];
  logic flush_misalign = 1'b0;

  initial begin : monitor
    int   mcyc;
    logic prev_flush, prev_mis;
    exp_t e;
    mcyc = 0; prev_flush = 1'b0; prev_mis = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      mcyc++;
      if (rst) begin
        prev_flush = 1'b0;
        continue;
      end
      if (prev_flush && !prev_mis) check("valid_after_flush", {63'b0, ctrl.valid}, 64'd0);
      if (if_flush) check("no_read_on_flush", {63'b0, ibus_read}, 64'd0);
      if (ctrl.valid && !if_stall && !if_flush) begin
        check("expected_available", {63'b0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_pc", {32'b0, data.pc}, {32'b0, e.pc});
          check("out_instr", {32'b0, data.instruction}, {32'b0, e.ins});
`ifdef IF_MISALIGN_CHECK_EN
          check("out_exc", {63'b0, ctrl.exception_instr_addr_misaligned}, {63'b0, e.exc});
`endif
        end
        pops++;
        pop_cyc.push_back(mcyc);
      end
      prev_flush = if_flush;
      prev_mis   = if_flush & flush_misalign;
    end
  end

  // Stimulus
  initial begin : stim
    logic [31:0] r;
    exp_t        e;
    int          start;
    rst = 1'b1; if_stall = 1'b0; if_flush = 1'b0; redirect_pc = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_read", {63'b0, ibus_read}, 64'd0);
    check("rst_valid", {63'b0, ctrl.valid}, 64'd0);
    check("rst_data", data, 64'd0);
    push_stream(ResetPc);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("no_read_in_release_cycle", {63'b0, ibus_read}, 64'd0);
    @(negedge clk);
    #1;
    check("first_read", {31'b0, ibus_read, ibus_address}, {31'b0, 1'b1, ResetPc});

    // Always-ready bus, one-cycle latency, no stall: one instruction per cycle.
    repeat (12) @(negedge clk);
    check("stream_started", {63'b0, pop_cyc.size() >= 4}, 64'd1);
    if (pop_cyc.size() >= 4)
      for (int i = 1; i < 4; i++)
        check("back_to_back", 64'(pop_cyc[i] - pop_cyc[0]), 64'(i));

    for (int seg = 0; seg < 30; seg++) begin
      @(negedge clk);
      wait_pct = $urandom_range(40);
      max_lat  = $urandom_range(4, 1);
      // Redirect, sometimes coincident with a stall.
      case ($urandom_range(7))
        0:       r = 32'hFFFF_FFF8;
        1:       r = ($urandom & 32'h0000_FFFC) | 32'h2;
        default: r = $urandom & 32'h0000_FFFC;
      endcase
      if_flush    = 1'b1;
      redirect_pc = r;
      if_stall    = ($urandom_range(1) == 0);
      exp_q.delete();
`ifdef IF_MISALIGN_CHECK_EN
      flush_misalign = (r[1:0] != 2'b00);
      halted         = flush_misalign;
      if (flush_misalign) begin
        e.pc = r; e.ins = 32'h0; e.exc = 1'b1;
        exp_q.push_back(e);
      end else begin
        push_stream(r);
      end
`else
      e.pc = r; e.ins = '0; e.exc = 1'b0;
      push_stream({e.pc[31:2], 2'b00});
`endif
      start = pops;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if_flush    = 1'b0;
        redirect_pc = $urandom;
        if_stall    = ($urandom_range(3) == 0);
      end
      check("segment_progress", {63'b0, pops > start}, 64'd1);
    end

    @(negedge clk);
    if_stall = 1'b0;
    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
